// File: rtl/alu_4_pkg.sv
// alu_4_pkg: shared select codes, limits and FSM states for the ALU_4 arbiter
package alu_4_pkg;
  localparam int DW_DEF = 4;
  localparam int SW_DEF = 4;
  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_AND  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_XOR  = 4'd4;
  localparam logic [3:0] SEL_NAND = 4'd5;
  localparam logic [3:0] SEL_NOR  = 4'd6;
  localparam logic [3:0] SEL_XNOR = 4'd7;
  localparam logic [3:0] SEL_NOT  = 4'd8;
  localparam logic [3:0] SEL_SHL  = 4'd9;
  localparam logic [3:0] SEL_SHR  = 4'd10;
  localparam logic [3:0] SEL_MAX  = SEL_SHR;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arb_2.sv
// rr_arb_2: combinational two-way round-robin grant selection
module rr_arb_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       grant,
  output logic       grant_valid
);
  assign grant       = (valid == 2'b11) ? ptr : valid[1];
  assign grant_valid = |valid;
endmodule

// File: rtl/alu_4_arbiter.sv
// alu_4_arbiter: shares one external ALU_4 between two requesters, tagged response channel
module alu_4_arbiter
  import alu_4_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*DW-1:0]   req_a,
  input  logic [2*DW-1:0]   req_b,
  input  logic [2*SW-1:0]   req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DW-1:0]     rsp_y,
  output logic              rsp_carry,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [SW-1:0]     alu_sel,
  input  logic [DW-1:0]     alu_y,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);
  state_t state, state_nx;
  logic ptr, id, grant, grant_valid, err, accept;
  rr_arb_2 u_arb (
    .valid(req_valid),
    .ptr(ptr),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  assign accept    = (state == IDLE) && grant_valid;
  assign req_ready = accept ? {grant, ~grant} : 2'b00;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign err       = alu_sel > SW'(SEL_MAX);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant_valid ? EXEC : IDLE;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= 1'b0;
      id           <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      rsp_id       <= 1'b0;
      rsp_y        <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        alu_a   <= grant ? req_a[2*DW-1:DW] : req_a[DW-1:0];
        alu_b   <= grant ? req_b[2*DW-1:DW] : req_b[DW-1:0];
        alu_sel <= grant ? req_sel[2*SW-1:SW] : req_sel[SW-1:0];
        id      <= grant;
        ptr     <= ~grant;
      end
      // illegal selects report an error with all result fields forced to zero
      if (state == EXEC) begin
        rsp_id       <= id;
        rsp_err      <= err;
        rsp_y        <= err ? '0 : alu_y;
        rsp_carry    <= !err && alu_carry;
        rsp_overflow <= !err && alu_overflow;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + CNT_W'(op_count != '1);
    end
  end
endmodule

// File: tb/tb_alu_4_arbiter.sv
// tb_alu_4_arbiter: scoreboard bench with a behavioural ALU_4 and arbitration model
module tb_alu_4_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req_a = '0, req_b = '0, req_sel = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_carry, rsp_overflow, rsp_err;
  logic [3:0] rsp_y, alu_a, alu_b, alu_sel, alu_y;
  logic       alu_carry, alu_overflow, busy;
  logic [7:0] op_count;
  typedef struct packed {logic id; logic [3:0] y; logic c; logic ov; logic err;} rsp_t;
  rsp_t q[$];
  rsp_t obs, prev, exp_r;
  int   checks = 0, errs = 0, cyc = 0, acc_cyc = 0, m_cnt = 0;
  logic m_ptr = 1'b0, m_free = 1'b1, prev_hold = 1'b0, g;
  logic [1:0] er;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_4_arbiter #(.DW(4), .SW(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_y(alu_y), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .busy(busy), .op_count(op_count)
  );
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [4:0] r;
    logic [3:0] y;
    logic c, ov;
    r = '0; y = '0; c = 1'b0; ov = 1'b0;
    case (s)
      4'd0: begin r = {1'b0, a} + {1'b0, b}; y = r[3:0]; c = r[4]; ov = (a[3] == b[3]) && (y[3] != a[3]); end
      4'd1: begin r = {1'b0, a} - {1'b0, b}; y = r[3:0]; c = r[4]; ov = (a[3] != b[3]) && (y[3] != a[3]); end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~(a & b);
      4'd6: y = ~(a | b);
      4'd7: y = ~(a ^ b);
      4'd8: y = ~a;
      4'd9: begin y = {a[2:0], 1'b0}; c = a[3]; ov = a[3] ^ a[2]; end
      4'd10: begin y = {1'b0, a[3:1]}; c = a[0]; end
      default: y = '0;
    endcase
    return {ov, c, y};
  endfunction
  always_comb {alu_overflow, alu_carry, alu_y} = alu_f(alu_a, alu_b, alu_sel);
  function automatic rsp_t expect_of(input logic r);
    logic [3:0] a, b, s;
    logic [5:0] f;
    a = r ? req_a[7:4] : req_a[3:0];
    b = r ? req_b[7:4] : req_b[3:0];
    s = r ? req_sel[7:4] : req_sel[3:0];
    f = alu_f(a, b, s);
    return (s > 4'd10) ? rsp_t'({r, 4'd0, 1'b0, 1'b0, 1'b1}) : rsp_t'({r, f[3:0], f[4], f[5], 1'b0});
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic fail_now(input string n);
    checks++;
    errs++;
    $display("FAIL %s: bound expired (t=%0t)", n, $time);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 1'b0; m_free = 1'b1; m_cnt = 0; prev_hold = 1'b0;
      q.delete();
    end else begin
      er = 2'b00; g = 1'b0;
      if (m_free && |req_valid) begin
        g  = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        er = g ? 2'b10 : 2'b01;
      end
      chk("req_ready", req_ready, er);
      chk("busy", busy, !m_free);
      chk("rsp_valid", rsp_valid, !m_free && cyc >= acc_cyc + 2);
      chk("op_count", op_count, m_cnt);
      obs = {rsp_id, rsp_y, rsp_carry, rsp_overflow, rsp_err};
      if (prev_hold && rsp_valid) chk("rsp_stable", obs, prev);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) fail_now("rsp_unexpected");
        else begin
          exp_r = q.pop_front();
          chk("rsp", obs, exp_r);
        end
        m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
        m_free = 1'b1;
      end
      if (er != 2'b00) begin
        q.push_back(expect_of(g));
        m_ptr = ~g; m_free = 1'b0; acc_cyc = cyc;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev = obs;
    end
  end
  task automatic send(input int r, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    req_a[r*4 +: 4] = a; req_b[r*4 +: 4] = b; req_sel[r*4 +: 4] = s;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[r]) break;
    end
    if (!req_ready[r]) fail_now("grant_timeout");
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask
  task automatic wait_rsp();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (!rsp_valid) fail_now("rsp_timeout");
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) fail_now("idle_timeout");
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_overflow, rsp_err,
                             alu_a, alu_b, alu_sel, busy, op_count}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 4'd6, 4'd11, 4'd0);
    wait_rsp();
    chk("t1_rsp", {rsp_id, rsp_y, rsp_carry, rsp_overflow, rsp_err}, {1'b0, 4'd1, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    send(1, 4'd7, 4'd1, 4'd0);
    wait_rsp();
    chk("t2_rsp", {rsp_id, rsp_y, rsp_carry, rsp_overflow, rsp_err}, {1'b1, 4'd8, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("t2_count", op_count, 2);
    req_a = {4'd6, 4'd6}; req_b = {4'd11, 4'd11}; req_sel = {4'd2, 4'd2};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      chk("t3_rr", {rsp_id, rsp_y}, {k[0], 4'd2});
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    wait_idle();
    @(posedge clk); #1;
    send(0, 4'd3, 4'd5, 4'hC);
    wait_rsp();
    chk("t4_err", {rsp_y, rsp_carry, rsp_overflow, rsp_err}, {4'd0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1, 4'd9, 4'd4, 4'd1);
    wait_rsp();
    @(posedge clk); #1;
    req_a[3:0] = 4'd5; req_b[3:0] = 4'd5; req_sel[3:0] = 4'd7; req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold", {req_ready, busy, rsp_valid, rsp_y}, {2'b00, 1'b1, 1'b1, 4'd5});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(0, 4'd5, 4'd5, 4'd7);
    wait_idle();
    @(posedge clk); #1;
    send(0, 4'd2, 4'd3, 4'd3);
    #2 rst_n = 1'b0;
    #1 chk("t6_reset", {req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_overflow, rsp_err,
                        alu_a, alu_b, alu_sel, busy, op_count}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_a = {4'd1, 4'd2}; req_b = {4'd1, 4'd2}; req_sel = {4'd0, 4'd0};
    req_valid = 2'b11;
    wait_rsp();
    chk("t6_ptr", {rsp_id, rsp_y}, {1'b0, 4'd4});
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    repeat (2000) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom);
      req_a = 8'($urandom); req_b = 8'($urandom); req_sel = 8'($urandom);
      rsp_ready = ($urandom % 4) != 0;
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    wait_idle();
    chk("sat_count", op_count, 255);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
